// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
//   Groups the execute-stage handshake and data signals.
//   Handshake semantics (both sides): a beat on a valid/ready pair transfers on
//   a rising clk edge where valid && ready; valid never waits on ready, and a
//   producer holding valid=1 keeps its payload stable until the transfer.
//   Signals:
//     in_valid/in_ready        ID/EX -> EX op handshake
//     alu_control/src_a/src_b  operation code and operands
//     rd_in/reg_write_in       sideband passed through to EX/MEM
//     flush                    kill held and incoming op
//     out_valid/out_ready      EX/MEM -> MEM result handshake
//     result/zero/rd_out/reg_write/illegal_op  registered EX/MEM contents
//   Modports: slave = the execute stage, master = the surrounding pipeline.
// -----------------------------------------------------------------------------
interface alu_exec_stage_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_control;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [RD_W-1:0] rd_in;
    logic            reg_write_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [RD_W-1:0] rd_out;
    logic            reg_write;
    logic            illegal_op;

    modport slave (
        input  in_valid, alu_control, src_a, src_b, rd_in, reg_write_in, flush,
               out_ready,
        output in_ready, out_valid, result, zero, rd_out, reg_write, illegal_op
    );

    modport master (
        output in_valid, alu_control, src_a, src_b, rd_in, reg_write_in, flush,
               out_ready,
        input  in_ready, out_valid, result, zero, rd_out, reg_write, illegal_op
    );
endinterface

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage: applies the 5-bit ALU control code to src_a/src_b and
//   registers the result plus sideband into the EX/MEM register, with a
//   one-entry valid/ready handshake, back-pressure and flush.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_exec_stage_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_exec_stage_if.slave       bus
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b10000;
    localparam logic [4:0] OP_SLL    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b10111;
    localparam logic [4:0] OP_SLTU   = 5'b11000;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_OR     = 5'b00010;
    localparam logic [4:0] OP_AND    = 5'b00001;
    localparam logic [4:0] OP_CSRRWI = 5'b11010;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic [RD_W-1:0] r_rd;
    logic            r_reg_write;
    logic            r_illegal;
    logic            r_valid;

    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_accept;
    logic            w_transfer;

    assign w_shamt = bus.src_b[SH_W-1:0];

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (bus.alu_control)
            OP_ADD:    w_result = bus.src_a + bus.src_b;
            OP_SUB:    w_result = bus.src_a - bus.src_b;
            OP_SLL:    w_result = bus.src_a << w_shamt;
            OP_SRL:    w_result = bus.src_a >> w_shamt;
            OP_SRA:    w_result = XLEN'($signed(bus.src_a) >>> w_shamt);
            OP_SLT:    w_result = {{(XLEN-1){1'b0}},
                                   ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLTU:   w_result = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_XOR:    w_result = bus.src_a ^ bus.src_b;
            OP_OR:     w_result = bus.src_a | bus.src_b;
            OP_AND:    w_result = bus.src_a & bus.src_b;
            OP_CSRRWI: w_result = bus.src_b;
            default:   w_illegal = 1'b1;
        endcase
    end

    // Space is available when empty or when the held result leaves this cycle.
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_transfer   = r_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_result    <= w_result;
            r_zero      <= (w_result == '0);
            r_rd        <= bus.rd_in;
            r_reg_write <= bus.reg_write_in;
            r_illegal   <= w_illegal;
        end else if (w_transfer) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.result     = r_result;
    assign bus.zero       = r_zero;
    assign bus.rd_out     = r_rd;
    // Gated by valid so an empty EX/MEM register can never request a write.
    assign bus.reg_write  = r_reg_write && r_valid;
    assign bus.illegal_op = r_illegal;
endmodule
